dmem_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing the single-port data memory between
//  NUM_REQ requesters (per-core cache controllers).
//  - Accepts one load/store request at a time and drives memory opcode/addr/wdata.
//  - Captures load data and returns a one-cycle response pulse to the winner.
//  - Sits between the per-core L1/L2 controllers and the data memory.

---
 rtl/dmem_rr_arbiter_if.sv | 41 ++++
 rtl/dmem_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_rr_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : dmem_rr_arbiter_if
// Brief   : Requester, response and memory-command bundle for dmem_rr_arbiter.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*DATA_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [6:0]                mem_opcode;
  logic [DATA_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_REQ*CNT_W-1:0]  grant_cnt;

  // Arbiter side
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_opcode, mem_addr, mem_wdata,
    output grant_cnt
  );

  // Requester / memory side
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_opcode, mem_addr, mem_wdata,
    input  grant_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dmem_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : dmem_rr_arbiter
// Brief   : Round-robin sequencer sharing a single-port data memory between
//           NUM_REQ requesters. Optional grant counters: DMEM_ARB_PERF_CNT_EN.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  wire                     clk,
  input  wire                     reset,
  dmem_rr_arbiter_if.master       bus
);
  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam int         LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IDLE  = 7'b0000000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             r_state,      w_state_n;
  logic [NUM_REQ-1:0] r_req_ready,  w_req_ready_n;
  logic [NUM_REQ-1:0] r_rsp_valid,  w_rsp_valid_n;
  logic [DATA_W-1:0]  r_rsp_rdata,  w_rsp_rdata_n;
  logic [6:0]         r_mem_opcode, w_mem_opcode_n;
  logic [DATA_W-1:0]  r_mem_addr,   w_mem_addr_n;
  logic [DATA_W-1:0]  r_mem_wdata,  w_mem_wdata_n;
  logic               r_we,         w_we_n;
  logic [LAT_W-1:0]   r_cnt,        w_cnt_n;
  logic [IDX_W-1:0]   r_last_grant, w_last_grant_n;

  logic [DATA_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = bus.req_addr [gi*DATA_W +: DATA_W];
    assign w_wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: lowest valid index above last_grant, else lowest overall.
  logic             w_any_hi, w_any_lo;
  logic [IDX_W-1:0] w_win_hi, w_win_lo, w_winner;

  always_comb begin
    w_any_hi = 1'b0;
    w_any_lo = 1'b0;
    w_win_hi = '0;
    w_win_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (IDX_W'(i) > r_last_grant) begin
          w_any_hi = 1'b1;
          w_win_hi = IDX_W'(i);
        end else begin
          w_any_lo = 1'b1;
          w_win_lo = IDX_W'(i);
        end
      end
    end
    w_winner = w_any_hi ? w_win_hi : w_win_lo;
  end

  always_comb begin
    w_state_n      = r_state;
    w_req_ready_n  = '0;
    w_rsp_valid_n  = '0;
    w_rsp_rdata_n  = r_rsp_rdata;
    w_mem_opcode_n = r_mem_opcode;
    w_mem_addr_n   = r_mem_addr;
    w_mem_wdata_n  = r_mem_wdata;
    w_we_n         = r_we;
    w_cnt_n        = r_cnt;
    w_last_grant_n = r_last_grant;

    case (r_state)
      S_IDLE: begin
        w_rsp_rdata_n  = '0;
        w_mem_opcode_n = OP_IDLE;
        w_mem_addr_n   = '0;
        w_mem_wdata_n  = '0;
        if (w_any_hi || w_any_lo) begin
          w_req_ready_n  = NUM_REQ'(1) << w_winner;
          w_last_grant_n = w_winner;
          w_we_n         = bus.req_we[w_winner];
          w_mem_opcode_n = bus.req_we[w_winner] ? OP_STORE : OP_LOAD;
          w_mem_addr_n   = w_addr_arr[w_winner] & ~DATA_W'(3);
          w_mem_wdata_n  = w_wdata_arr[w_winner];
          w_cnt_n        = LAT_W'(MEM_LAT - 1);
          w_state_n      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_rsp_rdata_n  = r_we ? '0 : bus.mem_rdata;
          w_mem_opcode_n = OP_IDLE;
          w_mem_addr_n   = '0;
          w_mem_wdata_n  = '0;
          w_state_n      = S_RESP;
        end else begin
          w_cnt_n = r_cnt - LAT_W'(1);
        end
      end
      S_RESP: begin
        w_rsp_valid_n = NUM_REQ'(1) << r_last_grant;
        w_state_n     = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_mem_opcode <= OP_IDLE;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_n;
      r_req_ready  <= w_req_ready_n;
      r_rsp_valid  <= w_rsp_valid_n;
      r_rsp_rdata  <= w_rsp_rdata_n;
      r_mem_opcode <= w_mem_opcode_n;
      r_mem_addr   <= w_mem_addr_n;
      r_mem_wdata  <= w_mem_wdata_n;
      r_we         <= w_we_n;
      r_cnt        <= w_cnt_n;
      r_last_grant <= w_last_grant_n;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.mem_opcode = r_mem_opcode;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

`ifdef DMEM_ARB_PERF_CNT_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf_cnt
    logic [CNT_W-1:0] r_grant_cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_grant_cnt <= '0;
      end else if (r_req_ready[gi] && (r_grant_cnt != '1)) begin
        r_grant_cnt <= r_grant_cnt + CNT_W'(1);
      end
    end
    assign bus.grant_cnt[gi*CNT_W +: CNT_W] = r_grant_cnt;
  end
`else
  assign bus.grant_cnt = {(NUM_REQ*CNT_W){1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_dmem_rr_arbiter
// Brief   : Scoreboard bench for dmem_rr_arbiter (NUM_REQ=2, MEM_LAT=1, CNT_W=2).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_rr_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 1;
  localparam int CNT_W   = 2;

  typedef struct {
    int          idx;
    logic [6:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dmem_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memory model: fixed word at 0x10, otherwise address-derived pattern
  assign bus.mem_rdata = (bus.mem_addr == 32'h10) ? 32'hDEADBEEF
                                                  : {bus.mem_addr[15:0], 16'hC0DE};

  grant_t gq[$];
  rsp_t   rq[$];
  int     ready_cyc_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     last_ready_cyc = -1;
  bit     spacing_chk = 1'b0;
  int     rem [NUM_REQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_grant(input int idx, input logic [6:0] op, input logic [31:0] a,
                           input logic [31:0] d);
    gq.push_back('{idx: idx, op: op, addr: a, wdata: d});
  endtask

  task automatic exp_rsp(input int idx, input logic [31:0] d);
    rq.push_back('{idx: idx, rdata: d});
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int n);
    rem[i] = n;
    bus.req_we[i] = we;
    bus.req_addr[i*DATA_W +: DATA_W]  = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Requesters hold valid until each grant, re-raising while transactions remain
  task automatic run(input int budget);
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_valid[i] = (rem[i] != 0);
    while ((rem[0] != 0 || rem[1] != 0 || rq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i] && rem[i] > 0) rem[i]--;
        bus.req_valid[i] = (rem[i] != 0);
      end
    end
    if (rem[0] != 0 || rem[1] != 0 || rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=pending required=done (t=%0t)", $time);
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or response
  initial begin
    grant_t g;
    rsp_t   r;
    forever begin
      @(negedge clk);
      if (!reset && bus.req_ready != '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", 32'(bus.req_ready), 32'h0);
        end else begin
          g = gq.pop_front();
          chk("grant_onehot", 32'(bus.req_ready), 32'(1) << g.idx);
          chk("mem_opcode", 32'(bus.mem_opcode), 32'(g.op));
          chk("mem_addr", bus.mem_addr, g.addr);
          chk("mem_wdata", bus.mem_wdata, g.wdata);
          if (spacing_chk && last_ready_cyc >= 0)
            chk("grant_spacing", 32'(cyc - last_ready_cyc), 32'(MEM_LAT + 2));
          last_ready_cyc = cyc;
          ready_cyc_q.push_back(cyc);
        end
      end
      if (!reset && bus.rsp_valid != '0) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
        end else begin
          r = rq.pop_front();
          chk("rsp_onehot", 32'(bus.rsp_valid), 32'(1) << r.idx);
          chk("rsp_rdata", bus.rsp_rdata, r.rdata);
          if (ready_cyc_q.size() != 0)
            chk("rsp_latency", 32'(cyc - ready_cyc_q.pop_front()), 32'(MEM_LAT + 1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rem[0] = 0;
    rem[1] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_mem_opcode", 32'(bus.mem_opcode), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_grant_cnt", 32'(bus.grant_cnt), 32'h0);

    // Single load
    set_req(0, 1'b0, 32'h10, 32'h0, 1);
    exp_grant(0, 7'h03, 32'h10, 32'h0);
    exp_rsp(0, 32'hDEADBEEF);
    run(50);

    // Misaligned store
    set_req(1, 1'b1, 32'h22, 32'hA5A5A5A5, 1);
    exp_grant(1, 7'h23, 32'h20, 32'hA5A5A5A5);
    exp_rsp(1, 32'h0);
    run(50);

    // Both held valid after reset: 0,1,0,1
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_req(0, 1'b0, 32'h40, 32'h0, 2);
    set_req(1, 1'b0, 32'h81, 32'h0, 2);
    for (int k = 0; k < 2; k++) begin
      exp_grant(0, 7'h03, 32'h40, 32'h0);
      exp_rsp(0, 32'h0040C0DE);
      exp_grant(1, 7'h03, 32'h80, 32'h0);
      exp_rsp(1, 32'h0080C0DE);
    end
    spacing_chk = 1'b1;
    last_ready_cyc = -1;
    run(100);

    // Sole requester re-granted back-to-back
    last_ready_cyc = -1;
    set_req(1, 1'b0, 32'h104, 32'h0, 3);
    for (int k = 0; k < 3; k++) begin
      exp_grant(1, 7'h03, 32'h104, 32'h0);
      exp_rsp(1, 32'h0104C0DE);
    end
    run(100);
    spacing_chk = 1'b0;

    // Reset during ACCESS of a store
    set_req(0, 1'b1, 32'h30, 32'h12345678, 0);
    exp_grant(0, 7'h23, 32'h30, 32'h12345678);
    bus.req_valid[0] = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.req_ready[0] && n < 10);
      chk("abort_store_granted", 32'(bus.req_ready[0]), 32'h1);
    end
    bus.req_valid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_opcode", 32'(bus.mem_opcode), 32'h0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    reset = 1'b0;
    ready_cyc_q.delete();
    repeat (4) @(negedge clk);

    // FSM back in IDLE: new request granted on the very next edge
    set_req(1, 1'b0, 32'h10, 32'h0, 0);
    exp_grant(1, 7'h03, 32'h10, 32'h0);
    exp_rsp(1, 32'hDEADBEEF);
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(bus.req_ready), 32'h2);
    bus.req_valid[1] = 1'b0;
    run(50);

    // Five grants to req0 for the saturating counter
    set_req(0, 1'b0, 32'h10, 32'h0, 5);
    for (int k = 0; k < 5; k++) begin
      exp_grant(0, 7'h03, 32'h10, 32'h0);
      exp_rsp(0, 32'hDEADBEEF);
    end
    run(200);
`ifdef DMEM_ARB_PERF_CNT_EN
    chk("grant_cnt0", 32'(bus.grant_cnt[1:0]), 32'd3);
    chk("grant_cnt1", 32'(bus.grant_cnt[3:2]), 32'd1);
`else
    chk("grant_cnt0", 32'(bus.grant_cnt[1:0]), 32'd0);
    chk("grant_cnt1", 32'(bus.grant_cnt[3:2]), 32'd0);
`endif

    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
